// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, datapath select
// codes, instruction Op field values and the ARM condition-code evaluator.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_FPEXEC  = 4'd10,
    S_FPWB    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_ORR   = 3'b011;
  localparam logic [2:0] ALU_MUL   = 3'b100;
  localparam logic [2:0] ALU_UMULL = 3'b101;
  localparam logic [2:0] ALU_SMULL = 3'b110;
  localparam logic [2:0] ALU_EOR   = 3'b111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_OPRES  = 2'b10;

  localparam logic [1:0] SRCA_REG    = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_FP  = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       mem_write;
    logic       reg_write;
    logic       mul_write;
    logic       ir_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [2:0] alu_control;
    logic       res_src;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  localparam ctrl_t CTRL_FETCH = '{
    pc_write:    1'b1,
    mem_write:   1'b0,
    reg_write:   1'b0,
    mul_write:   1'b0,
    ir_write:    1'b1,
    adr_src:     1'b0,
    alu_src_a:   SRCA_PC,
    alu_src_b:   SRCB_FOUR,
    result_src:  RES_OPRES,
    alu_control: ALU_ADD,
    res_src:     1'b0
  };

  // nzcv is packed {N,Z,C,V}; cond 4'b1111 never executes.
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    logic ok;
    {n, z, c, v} = nzcv;
    case (cond)
      4'h0:    ok = z;
      4'h1:    ok = !z;
      4'h2:    ok = c;
      4'h3:    ok = !c;
      4'h4:    ok = n;
      4'h5:    ok = !n;
      4'h6:    ok = v;
      4'h7:    ok = !v;
      4'h8:    ok = c && !z;
      4'h9:    ok = !c || z;
      4'hA:    ok = (n == v);
      4'hB:    ok = (n != v);
      4'hC:    ok = !z && (n == v);
      4'hD:    ok = z || (n != v);
      4'hE:    ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mc_control_fsm_condcheck.sv
// Condition-code evaluation of the latched instruction against the NZCV register.
module mc_condcheck
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ex_o
);

  assign cond_ex_o = cond_check(cond_i, flags_i);

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle ARM-subset control unit: sequences the shared datapath, owns NZCV.
// Control outputs are registered one state ahead; RegSrc/ImmSrc/FPUControl decode the IR directly.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned FP_EN  = 1,
  parameter int unsigned MUL_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic [3:0]  FPUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        MulWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [2:0]  ALUControl,
  output logic        ResSrc,
  output logic [1:0]  FPUControl,
  output logic [3:0]  Flags,
  output logic [3:0]  State
);

  state_t      state_q, state_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic [3:0]  flags_q;

  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rd;
  logic        s_bit;
  logic        rd_is_pc;
  logic        cond_ex;

  logic        mul_enc;
  logic [2:0]  mul_code;
  logic [2:0]  dp_code;
  logic [2:0]  alu_dp;
  logic        is_cmp;
  logic        is_long_mul;

  logic        unused_instr_bits;

  assign op       = Instr[27:26];
  assign funct    = Instr[25:20];
  assign rd       = Instr[15:12];
  assign s_bit    = funct[0];
  assign rd_is_pc = (rd == 4'd15);

  assign unused_instr_bits = ^{Instr[19:16], Instr[11:8], Instr[3:0]};

  mc_condcheck u_condcheck (
    .cond_i    (Instr[31:28]),
    .flags_i   (flags_q),
    .cond_ex_o (cond_ex)
  );

  // Data-processing ALU operation, with the multiply encodings taking priority.
  always_comb begin
    mul_enc  = 1'b0;
    mul_code = ALU_MUL;
    if ((op == OP_DP) && !funct[5] && (Instr[7:4] == 4'b1001)) begin
      case (Instr[23:21])
        3'b000:  begin mul_enc = 1'b1; mul_code = ALU_MUL;   end
        3'b100:  begin mul_enc = 1'b1; mul_code = ALU_UMULL; end
        3'b110:  begin mul_enc = 1'b1; mul_code = ALU_SMULL; end
        default: begin mul_enc = 1'b0; mul_code = ALU_MUL;   end
      endcase
    end

    case (funct[4:1])
      4'b0100: dp_code = ALU_ADD;
      4'b0010: dp_code = ALU_SUB;
      4'b1010: dp_code = ALU_SUB;
      4'b0000: dp_code = ALU_AND;
      4'b1100: dp_code = ALU_ORR;
      4'b0001: dp_code = ALU_EOR;
      default: dp_code = ALU_ADD;
    endcase

    if (mul_enc) begin
      alu_dp = (MUL_EN != 0) ? mul_code : ALU_AND;
    end else begin
      alu_dp = dp_code;
    end
    is_cmp      = !mul_enc && (funct[4:1] == 4'b1010);
    is_long_mul = mul_enc && (MUL_EN != 0) &&
                  ((mul_code == ALU_UMULL) || (mul_code == ALU_SMULL));
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_DP:   state_d = funct[5] ? S_EXECI : S_EXECR;
          OP_MEM:  state_d = S_MEMADR;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = (FP_EN != 0) ? S_FPEXEC : S_ILLEGAL;
        endcase
      end
      S_MEMADR:  state_d = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_EXECR,
      S_EXECI:   state_d = S_ALUWB;
      S_FPEXEC:  state_d = S_FPWB;
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_FETCH;
    endcase
  end

  // Outputs for the state being entered; cond_ex still sees the pre-update flags here,
  // so writeback decisions use the flags the instruction was issued against.
  always_comb begin
    ctrl_d = CTRL_IDLE;
    case (state_d)
      S_FETCH:  ctrl_d = CTRL_FETCH;
      S_DECODE: begin
        ctrl_d.alu_src_a  = SRCA_PC;
        ctrl_d.alu_src_b  = SRCB_FOUR;
        ctrl_d.result_src = RES_OPRES;
      end
      S_MEMADR: begin
        ctrl_d.alu_src_b   = SRCB_IMM;
        ctrl_d.alu_control = funct[3] ? ALU_ADD : ALU_SUB;
      end
      S_MEMRD:  ctrl_d.adr_src = 1'b1;
      S_MEMWB: begin
        ctrl_d.result_src = RES_DATA;
        ctrl_d.reg_write  = cond_ex;
        ctrl_d.pc_write   = cond_ex && rd_is_pc;
      end
      S_MEMWR: begin
        ctrl_d.adr_src   = 1'b1;
        ctrl_d.mem_write = cond_ex;
      end
      S_EXECR:  ctrl_d.alu_control = alu_dp;
      S_EXECI: begin
        ctrl_d.alu_src_b   = SRCB_IMM;
        ctrl_d.alu_control = alu_dp;
      end
      S_ALUWB: begin
        ctrl_d.alu_control = alu_dp;
        ctrl_d.reg_write   = cond_ex && !is_cmp;
        ctrl_d.mul_write   = cond_ex && is_long_mul;
        ctrl_d.pc_write    = cond_ex && !is_cmp && rd_is_pc;
      end
      S_BRANCH: begin
        ctrl_d.alu_src_a  = SRCA_ALUOUT;
        ctrl_d.alu_src_b  = SRCB_IMM;
        ctrl_d.result_src = RES_OPRES;
        ctrl_d.pc_write   = cond_ex;
      end
      S_FPEXEC: ctrl_d.res_src = 1'b1;
      S_FPWB: begin
        ctrl_d.reg_write = cond_ex;
        ctrl_d.pc_write  = cond_ex && rd_is_pc;
      end
      default:  ctrl_d = CTRL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= CTRL_FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      if (((state_q == S_EXECR) || (state_q == S_EXECI)) && s_bit && cond_ex) begin
        flags_q <= ALUFlags;
      end else if ((state_q == S_FPEXEC) && s_bit && cond_ex) begin
        flags_q <= FPUFlags;
      end
    end
  end

  // Enables are forced low while reset is held; selects keep their FETCH values.
  assign PCWrite    = ctrl_q.pc_write  & reset;
  assign MemWrite   = ctrl_q.mem_write & reset;
  assign RegWrite   = ctrl_q.reg_write & reset;
  assign MulWrite   = ctrl_q.mul_write & reset;
  assign IRWrite    = ctrl_q.ir_write  & reset;
  assign AdrSrc     = ctrl_q.adr_src;
  assign ALUSrcA    = ctrl_q.alu_src_a;
  assign ALUSrcB    = ctrl_q.alu_src_b;
  assign ResultSrc  = ctrl_q.result_src;
  assign ALUControl = ctrl_q.alu_control;
  assign ResSrc     = ctrl_q.res_src;

  assign RegSrc     = (state_q == S_FETCH) ? 2'b00 : {op == OP_MEM, op == OP_BR};
  assign ImmSrc     = ((state_q == S_FETCH) || (op == OP_FP)) ? IMM_DP : op;
  assign FPUControl = ((state_q == S_FPEXEC) || (state_q == S_FPWB)) ? Instr[21:20] : 2'b00;
  assign Flags      = flags_q;
  assign State      = state_q;

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Control unit for the multicycle ARM-subset processor. It sequences the shared datapath (PC/IR/data registers, register file, ALU, FPU, ALUOut) through fetch, decode, execute, memory and writeback steps.
- It decodes the latched instruction, holds the NZCV condition flags, and evaluates the condition code.
- It drives every datapath select and enable. It is instantiated beside the datapath in the processor top.

Parameters:
- FP_EN, 1, when 1 Op=2'b11 instructions use the FPU; when 0 they trap to state ILLEGAL.
- MUL_EN, 1, when 1 multiply encodings are decoded; when 0 they execute as AND.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- Instr  in  32  instruction register contents
- ALUFlags  in  4  NZCV from ALU
- FPUFlags  in  4  NZCV from FPU
- PCWrite  out  1  PC register enable
- MemWrite  out  1  data memory write strobe
- RegWrite  out  1  register-file port 3 write enable
- MulWrite  out  1  register-file port 4 write enable (long-multiply high word)
- IRWrite  out  1  instruction register enable
- AdrSrc  out  1  0=PC, 1=Result to memory address
- RegSrc  out  2  [0] RA1=R15, [1] RA2=Rd
- ALUSrcA  out  2  00=A, 01=PC, 10=ALUOut
- ALUSrcB  out  2  00=WriteData, 01=ExtImm, 10=constant 4
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=OpResult
- ImmSrc  out  2  00=dp imm8, 01=mem imm12, 10=branch imm24
- ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MUL, 101 UMULL, 110 SMULL, 111 EOR
- ResSrc  out  1  0=ALU, 1=FPU result
- FPUControl  out  2  Instr[21:20] in FP states, else 00
- Flags  out  4  current NZCV register
- State  out  4  FSM state encoding, exported for verification

Behaviour:
- Reset (reset=0, asynchronous): State=FETCH; Flags=0000; all enables 0. Select outputs take their FETCH values.
- Decode fields: Op=Instr[27:26], Funct=Instr[25:20], Cond=Instr[31:28], Rd=Instr[15:12], S=Funct[0].
- Multiply: Op=00, Funct[5]=0, Instr[7:4]=1001; Instr[23:21] 000 gives MUL, 100 gives UMULL, 110 gives SMULL.
- CondEx is combinational from Cond and the Flags register: EQ…AL as ARM; 4'b1111 gives 0.
- State FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1 (unconditional). Next state DECODE.
- State DECODE: ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=10. ALUOut gets PC+8. RegSrc/ImmSrc are driven from Op in DECODE and every later state. Next state by Op:
  - 00: EXECR if Funct[5]=0, else EXECI.
  - 01: MEMADR.
  - 10: BRANCH.
  - 11: FPEXEC (or ILLEGAL if FP_EN=0).
- State MEMADR: ALUSrcA=00, ALUSrcB=01. ADD if Funct[3]=1, else SUB. Next state MEMRD if Funct[0]=1, else MEMWR.
- State MEMRD: AdrSrc=1, ResultSrc=00. Next state MEMWB.
- State MEMWB: ResultSrc=01, RegWrite=CondEx. Next state FETCH.
- State MEMWR: AdrSrc=1, MemWrite=CondEx. Next state FETCH.
- States EXECR/EXECI: ALUSrcA=00, ALUSrcB=00 (EXECR) or 01 (EXECI). ALUControl from Funct[4:1]:
  - 0100 gives ADD; 0010 and 1010 (CMP) give SUB; 0000 gives AND; 1100 gives ORR; 0001 gives EOR.
  - A multiply encoding overrides this.
  - Next state ALUWB.
- State ALUWB: ResultSrc=00.
  - RegWrite=CondEx, except CMP, where RegWrite=0.
  - MulWrite=CondEx for UMULL/SMULL. ALUControl is held from EXECR so ALUResult2 stays valid.
  - Flags<=ALUFlags when S&CondEx, registered at the end of EXECR/EXECI.
  - Next state FETCH.
- State BRANCH: ALUSrcA=10, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondEx. Next state FETCH.
- State FPEXEC: ALUSrcA=00, ALUSrcB=00, ResSrc=1. Flags<=FPUFlags when S&CondEx. Next state FPWB.
- State FPWB: ResultSrc=00, RegWrite=CondEx. Next state FETCH.
- Rd=15 writeback in MEMWB/ALUWB/FPWB: PCWrite=CondEx as well.
- State ILLEGAL: all enables 0. The FSM stays here until reset.
- Latency per instruction class:
  - LDR 5 cycles; STR 4.
  - Data-processing 4; FP 4.
  - Branch 3.
- An unknown State encoding returns to FETCH with all enables 0.

Decomposition:
- Package mc_ctrl_pkg holds:
  - the state encodings (4-bit);
  - the ALUControl, ResultSrc, ALUSrcA/B and ImmSrc codes;
  - the Op field codes;
  - a cond-check function.
- One sub-module, mc_condcheck, computes CondEx from Cond and Flags.

Test Plan:
- Reset=0 asserted mid-MEMRD -> State=FETCH immediately, Flags=0000, MemWrite=0; after release FETCH drives IRWrite=1, PCWrite=1.
- ADDS R1,R2,R3 (0xE0921003) with ALUFlags=0100 -> states FETCH,DECODE,EXECR,ALUWB; RegWrite=1 only in ALUWB; Flags=0100 after EXECR.
- BEQ (0x0A000002) with Flags Z=0 -> BRANCH state with PCWrite=0; with Z=1 -> PCWrite=1, ALUSrcA=10, ResultSrc=10.
- LDR (0xE5921004) -> 5 cycles; AdrSrc=1 in MEMRD; MEMWB has ResultSrc=01, RegWrite=1. STR (0xE5821004) -> MemWrite=1 in MEMWR only.
- UMULL (0xE0854392) -> ALUWB with ALUControl=101, RegWrite=1, MulWrite=1. MUL -> MulWrite=0.
- FP op Op=11 with FP_EN=1 -> FPEXEC asserts ResSrc=1 and FPUControl=Instr[21:20]; with FP_EN=0 -> ILLEGAL, held there, no enables.
